// File: rtl/dram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dram_arb_pkg
// Purpose  : Shared types for the two-master data-RAM arbiter: FSM states,
//            master identifiers, the latched request record and the
//            address range check.
// Revision : 1.0 - initial release
// ============================================================================
package dram_arb_pkg;

  // Bus width of the request record; the arbiter is built for this width.
  localparam int BUS_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } arb_mst_t;

  typedef struct packed {
    logic                we;
    logic [BUS_XLEN-1:0] addr;
    logic [BUS_XLEN-1:0] wdata;
    logic [3:0]          be;
  } bus_req_t;

  // A word access is out of range when its last byte lies at or beyond the
  // mapped size. One extra bit keeps addresses near the top from wrapping.
  function automatic logic addr_out_of_range(input logic [BUS_XLEN-1:0] addr,
                                             input logic [BUS_XLEN-1:0] depth);
    logic [BUS_XLEN:0] end_addr;
    end_addr = {1'b0, addr} + (BUS_XLEN+1)'(4);
    return end_addr > {1'b0, depth};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dram_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : dram_arb_if
// Purpose  : Request/response bus between one master and the data-RAM
//            arbiter. The master drives the request, the arbiter answers
//            with rdy and a one-cycle response pulse.
// Revision : 1.0 - initial release
// ============================================================================
interface dram_arb_if #(
  parameter int XLEN = 32
) ();

  logic            req_vld;
  logic            req_rdy;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [3:0]      req_be;
  logic            rsp_vld;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  modport master (
    output req_vld, req_we, req_addr, req_wdata, req_be,
    input  req_rdy, rsp_vld, rsp_data, rsp_err
  );

  modport slave (
    input  req_vld, req_we, req_addr, req_wdata, req_be,
    output req_rdy, rsp_vld, rsp_data, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/dram_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : dram_arb_rr_arb2
// Purpose  : Combinational two-way pick. Fixed priority (M0 first) when
//            PRIO_MODE is nonzero, otherwise the master named by rr_ptr is
//            preferred and the other one is taken only when it is alone.
// Revision : 1.0 - initial release
// ============================================================================
module dram_arb_rr_arb2
  import dram_arb_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic [1:0] vld,
  input  arb_mst_t   rr_ptr,
  output logic [1:0] gnt,
  output arb_mst_t   winner
);

  // Pick at most one requester; gnt is one-hot or zero.
  always_comb begin
    gnt    = 2'b00;
    winner = M0;
    if ((PRIO_MODE != 0) || (rr_ptr == M0)) begin
      if (vld[0]) begin
        gnt    = 2'b01;
        winner = M0;
      end else if (vld[1]) begin
        gnt    = 2'b10;
        winner = M1;
      end
    end else begin
      if (vld[1]) begin
        gnt    = 2'b10;
        winner = M1;
      end else if (vld[0]) begin
        gnt    = 2'b01;
        winner = M0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dram_arb.sv
`default_nettype none
// ============================================================================
// Module   : dram_arb
// Purpose  : Two-master arbiter for the single data-RAM port. Accepts one
//            request at a time in IDLE, issues it to the RAM from a latched
//            copy in ISSUE and returns the response to the owner in RESP.
// Revision : 1.0 - initial release
// ============================================================================
module dram_arb
  import dram_arb_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] DEPTH_BYTES = 32'h8000,
  parameter int              PRIO_MODE   = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dram_arb_if.slave       m0,
  dram_arb_if.slave       m1,
  output logic [XLEN-1:0] mem_rd_addr_o,
  output logic [XLEN-1:0] mem_wr_addr_o,
  output logic [XLEN-1:0] mem_wr_data_o,
  output logic [3:0]      mem_wr_byte_en_o,
  input  logic [XLEN-1:0] mem_rd_data_i
);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  arb_mst_t        r_owner;
  arb_mst_t        r_rr_ptr;
  arb_mst_t        w_winner;
  bus_req_t        r_req;
  bus_req_t        w_req_sel;
  logic [1:0]      w_gnt;
  logic [1:0]      w_rdy;
  logic [1:0]      w_rsp_vld;
  logic            w_rsp_err;
  logic [XLEN-1:0] w_rsp_data;
  logic [3:0]      w_byte_en;
  logic            w_oor;

  dram_arb_rr_arb2 #(
    .PRIO_MODE (PRIO_MODE)
  ) u_pick (
    .vld    ({m1.req_vld, m0.req_vld}),
    .rr_ptr (r_rr_ptr),
    .gnt    (w_gnt),
    .winner (w_winner)
  );

  // Route the winning master's payload toward the request latch.
  always_comb begin
    if (w_winner == M1) begin
      w_req_sel = '{we: m1.req_we, addr: m1.req_addr, wdata: m1.req_wdata, be: m1.req_be};
    end else begin
      w_req_sel = '{we: m0.req_we, addr: m0.req_addr, wdata: m0.req_wdata, be: m0.req_be};
    end
  end

  // The range check works on the latched address, so it is stable for ISSUE and RESP.
  assign w_oor = addr_out_of_range(r_req.addr, DEPTH_BYTES);

  // State register, request latch and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_owner  <= M0;
      r_rr_ptr <= M0;
      r_req    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && (|w_gnt)) begin
        r_owner <= w_winner;
        r_req   <= w_req_sel;
      end
      if ((r_state == RESP) && (PRIO_MODE == 0)) begin
        r_rr_ptr <= (r_owner == M0) ? M1 : M0;
      end
    end
  end

  // Next state plus the per-state handshake, strobe and response values.
  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 2'b00;
    w_byte_en   = 4'b0000;
    w_rsp_vld   = 2'b00;
    w_rsp_err   = 1'b0;
    w_rsp_data  = '0;
    case (r_state)
      IDLE: begin
        if (|w_gnt) begin
          w_rdy       = w_gnt;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // Out-of-range writes never reach the RAM.
        if (r_req.we && !w_oor) begin
          w_byte_en = r_req.be;
        end
        w_state_nxt = RESP;
      end
      RESP: begin
        w_rsp_vld = (r_owner == M1) ? 2'b10 : 2'b01;
        w_rsp_err = w_oor;
        if (!r_req.we && !w_oor) begin
          w_rsp_data = mem_rd_data_i;
        end
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign m0.req_rdy  = w_rdy[0];
  assign m1.req_rdy  = w_rdy[1];
  assign m0.rsp_vld  = w_rsp_vld[0];
  assign m1.rsp_vld  = w_rsp_vld[1];
  assign m0.rsp_err  = w_rsp_vld[0] & w_rsp_err;
  assign m1.rsp_err  = w_rsp_vld[1] & w_rsp_err;
  assign m0.rsp_data = w_rsp_vld[0] ? w_rsp_data : '0;
  assign m1.rsp_data = w_rsp_vld[1] ? w_rsp_data : '0;

  assign mem_rd_addr_o    = r_req.addr;
  assign mem_wr_addr_o    = r_req.addr;
  assign mem_wr_data_o    = r_req.wdata;
  assign mem_wr_byte_en_o = w_byte_en;

endmodule
`default_nettype wire

// File: tb/tb_dram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_arb
// Purpose  : Directed bench for dram_arb: one round-robin instance backed by
//            a small synchronous RAM, one fixed-priority instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dram_arb_if #(.XLEN(32)) m0_bus ();
  dram_arb_if #(.XLEN(32)) m1_bus ();
  dram_arb_if #(.XLEN(32)) p0_bus ();
  dram_arb_if #(.XLEN(32)) p1_bus ();

  logic [31:0] rd_addr, wr_addr, wr_data, rd_data;
  logic [3:0]  wr_be;
  logic [31:0] p_rd_addr, p_wr_addr, p_wr_data;
  logic [3:0]  p_wr_be;
  logic [31:0] ram [0:63];

  dram_arb #(.XLEN(32), .DEPTH_BYTES(32'h8000), .PRIO_MODE(0)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .m0               (m0_bus),
    .m1               (m1_bus),
    .mem_rd_addr_o    (rd_addr),
    .mem_wr_addr_o    (wr_addr),
    .mem_wr_data_o    (wr_data),
    .mem_wr_byte_en_o (wr_be),
    .mem_rd_data_i    (rd_data)
  );

  dram_arb #(.XLEN(32), .DEPTH_BYTES(32'h8000), .PRIO_MODE(1)) dut_pr (
    .clk_i            (clk),
    .rst_i            (rst),
    .m0               (p0_bus),
    .m1               (p1_bus),
    .mem_rd_addr_o    (p_rd_addr),
    .mem_wr_addr_o    (p_wr_addr),
    .mem_wr_data_o    (p_wr_data),
    .mem_wr_byte_en_o (p_wr_be),
    .mem_rd_data_i    (32'h0)
  );

  // Synchronous RAM seen by the round-robin instance; preloaded while in reset.
  always @(posedge clk) begin
    if (rst) begin
      ram[4]  <= 32'hDEADBEEF;
      ram[5]  <= 32'hCAFEF00D;
      ram[8]  <= 32'h0;
      ram[63] <= 32'h0BADC0DE;
      rd_data <= 32'h0;
    end else begin
      rd_data <= ram[rd_addr[7:2]];
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) ram[wr_addr[7:2]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_m0(input logic vld, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    m0_bus.req_vld = vld; m0_bus.req_we = we; m0_bus.req_addr = addr;
    m0_bus.req_wdata = wdata; m0_bus.req_be = be;
  endtask

  task automatic set_m1(input logic vld, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    m1_bus.req_vld = vld; m1_bus.req_we = we; m1_bus.req_addr = addr;
    m1_bus.req_wdata = wdata; m1_bus.req_be = be;
  endtask

  task automatic set_p(input logic vld0, input logic vld1);
    p0_bus.req_vld = vld0; p0_bus.req_we = 1'b0; p0_bus.req_addr = 32'h40;
    p0_bus.req_wdata = 32'h0; p0_bus.req_be = 4'h0;
    p1_bus.req_vld = vld1; p1_bus.req_we = 1'b0; p1_bus.req_addr = 32'h44;
    p1_bus.req_wdata = 32'h0; p1_bus.req_be = 4'h0;
  endtask

  // Directed sequence; every transaction is accept, issue, respond.
  initial begin
    set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_p(1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state
    smp();
    chk("rst_rdy0", 32'(m0_bus.req_rdy), 32'h0);
    chk("rst_rdy1", 32'(m1_bus.req_rdy), 32'h0);
    chk("rst_rspv0", 32'(m0_bus.rsp_vld), 32'h0);
    chk("rst_rspv1", 32'(m1_bus.rsp_vld), 32'h0);
    chk("rst_rspd0", m0_bus.rsp_data, 32'h0);
    chk("rst_rdaddr", rd_addr, 32'h0);
    chk("rst_be", 32'(wr_be), 32'h0);
    nxt(); rst = 1'b0;

    // 1: M0 read of 0x10 alone
    set_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    smp();
    chk("t1_rdy0", 32'(m0_bus.req_rdy), 32'h1);
    chk("t1_rdy1", 32'(m1_bus.req_rdy), 32'h0);
    nxt(); set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    smp();
    chk("t1_rdaddr", rd_addr, 32'h10);
    chk("t1_be", 32'(wr_be), 32'h0);
    chk("t1_rdy0_issue", 32'(m0_bus.req_rdy), 32'h0);
    nxt(); smp();
    chk("t1_rspv0", 32'(m0_bus.rsp_vld), 32'h1);
    chk("t1_rspd0", m0_bus.rsp_data, 32'hDEADBEEF);
    chk("t1_err0", 32'(m0_bus.rsp_err), 32'h0);
    chk("t1_rspv1", 32'(m1_bus.rsp_vld), 32'h0);
    nxt();

    // 2: M1 partial write of 0x20
    set_m1(1'b1, 1'b1, 32'h20, 32'h12345678, 4'b0011);
    smp();
    chk("t2_rdy1", 32'(m1_bus.req_rdy), 32'h1);
    chk("t2_rdy0", 32'(m0_bus.req_rdy), 32'h0);
    nxt(); set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    smp();
    chk("t2_be", 32'(wr_be), 32'h3);
    chk("t2_wraddr", wr_addr, 32'h20);
    chk("t2_wrdata", wr_data, 32'h12345678);
    nxt(); smp();
    chk("t2_rspv1", 32'(m1_bus.rsp_vld), 32'h1);
    chk("t2_rspd1", m1_bus.rsp_data, 32'h0);
    chk("t2_err1", 32'(m1_bus.rsp_err), 32'h0);
    chk("t2_be_resp", 32'(wr_be), 32'h0);
    chk("t2_rspv0", 32'(m0_bus.rsp_vld), 32'h0);
    nxt();
    chk("t2_ram", ram[8], 32'h00005678);

    // 3: both masters valid continuously, round-robin alternates
    set_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    set_m1(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("t3_rdy0", 32'(m0_bus.req_rdy), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("t3_rdy1", 32'(m1_bus.req_rdy), (k % 2 == 0) ? 32'h0 : 32'h1);
      nxt();
      if (k == 3) begin
        set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
      smp();
      chk("t3_rdy_issue", 32'({m1_bus.req_rdy, m0_bus.req_rdy}), 32'h0);
      nxt(); smp();
      chk("t3_rspv", 32'({m1_bus.rsp_vld, m0_bus.rsp_vld}), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("t3_rspd", (k % 2 == 0) ? m0_bus.rsp_data : m1_bus.rsp_data,
          (k % 2 == 0) ? 32'hDEADBEEF : 32'hCAFEF00D);
      nxt();
    end

    // 4: fixed priority, both valid continuously
    set_p(1'b1, 1'b1);
    for (int c = 0; c < 9; c++) begin
      smp();
      chk("t4_rdy0", 32'(p0_bus.req_rdy), (c % 3 == 0) ? 32'h1 : 32'h0);
      chk("t4_rdy1", 32'(p1_bus.req_rdy), 32'h0);
      if (c == 1) chk("t4_rdaddr", p_rd_addr, 32'h40);
      nxt();
    end
    set_p(1'b0, 1'b0);

    // 5: out-of-range write at DEPTH_BYTES
    set_m0(1'b1, 1'b1, 32'h8000, 32'hFFFFFFFF, 4'hF);
    smp();
    chk("t5_rdy0", 32'(m0_bus.req_rdy), 32'h1);
    nxt(); set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    smp();
    chk("t5_be", 32'(wr_be), 32'h0);
    nxt(); smp();
    chk("t5_rspv0", 32'(m0_bus.rsp_vld), 32'h1);
    chk("t5_err0", 32'(m0_bus.rsp_err), 32'h1);
    chk("t5_rspd0", m0_bus.rsp_data, 32'h0);
    nxt();

    // 5b: last in-range word reads normally
    set_m0(1'b1, 1'b0, 32'h7FFC, 32'h0, 4'h0);
    smp();
    chk("t5b_rdy0", 32'(m0_bus.req_rdy), 32'h1);
    nxt(); set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    smp(); nxt(); smp();
    chk("t5b_err0", 32'(m0_bus.rsp_err), 32'h0);
    chk("t5b_rspd0", m0_bus.rsp_data, 32'h0BADC0DE);
    nxt();

    // 5c: address near the top of the space must not wrap into range
    set_m0(1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 4'h0);
    smp(); nxt(); set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    smp(); nxt(); smp();
    chk("t5c_rspv0", 32'(m0_bus.rsp_vld), 32'h1);
    chk("t5c_err0", 32'(m0_bus.rsp_err), 32'h1);
    chk("t5c_rspd0", m0_bus.rsp_data, 32'h0);
    nxt();

    // 6: reset during ISSUE of an M1 write
    set_m1(1'b1, 1'b1, 32'h24, 32'hAAAAAAAA, 4'hF);
    smp();
    chk("t6_rdy1", 32'(m1_bus.req_rdy), 32'h1);
    nxt(); set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    smp();
    chk("t6_be_issue", 32'(wr_be), 32'hF);
    rst = 1'b1;
    nxt(); rst = 1'b0;
    smp();
    chk("t6_be_after", 32'(wr_be), 32'h0);
    chk("t6_rspv1", 32'(m1_bus.rsp_vld), 32'h0);
    chk("t6_rspv0", 32'(m0_bus.rsp_vld), 32'h0);
    nxt();
    set_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    set_m1(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    smp();
    chk("t6_ptr_rdy0", 32'(m0_bus.req_rdy), 32'h1);
    chk("t6_ptr_rdy1", 32'(m1_bus.req_rdy), 32'h0);
    chk("t6_rspv1_idle", 32'(m1_bus.rsp_vld), 32'h0);
    nxt();
    set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
